// File: rtl/nibble_word_packer.sv
// Packs a valid-qualified nibble stream MSB-first into words and buffers them in a FWFT FIFO.
// Optional macro NIBBLE_PACKER_PARITY_EN adds a stored even-parity bit per word (WORD_PAR).
module nibble_word_packer #(
    parameter int NIBBLES_PER_WORD = 8,
    parameter int FIFO_DEPTH       = 4,
    localparam int W   = 4 * NIBBLES_PER_WORD,
    localparam int PCW = $clog2(NIBBLES_PER_WORD),
    localparam int PW  = $clog2(FIFO_DEPTH),
    localparam int LW  = PW + 1
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [3:0]     NIBBLE_IN,
    input  logic           NIBBLE_VALID,
    input  logic           FLUSH,
    output logic [W-1:0]   WORD_OUT,
    output logic           WORD_VALID,
    input  logic           WORD_READY,
    output logic [LW-1:0]  FIFO_LEVEL,
    output logic [PCW-1:0] PART_COUNT,
`ifdef NIBBLE_PACKER_PARITY_EN
    output logic           WORD_PAR,
`endif
    output logic           OVF_ERR
);

    localparam logic [PCW-1:0] LAST_SLOT = PCW'(NIBBLES_PER_WORD - 1);
    localparam logic [LW-1:0]  DEPTH_LVL = LW'(FIFO_DEPTH);

    logic [W-1:0]   part_word;
    logic [PCW-1:0] part_cnt;
    logic [W-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [LW-1:0]  level;
    logic           ovf;

    logic [W-1:0]   merged;
    logic           push, pop, accept;

    // Unfilled slots of part_word are always zero, so OR-ing in the new nibble is enough.
    always_comb begin
        merged = part_word;
        if (NIBBLE_VALID)
            merged = part_word | (W'(NIBBLE_IN) << (4 * (NIBBLES_PER_WORD - 1 - int'(part_cnt))));
        push   = (NIBBLE_VALID && part_cnt == LAST_SLOT) ||
                 (FLUSH && (NIBBLE_VALID || part_cnt != '0));
        pop    = (level != '0) && WORD_READY;
        accept = push && ((level < DEPTH_LVL) || pop);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            part_word <= '0;
            part_cnt  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            ovf       <= 1'b0;
        end else begin
            if (push) begin
                part_word <= '0;
                part_cnt  <= '0;
            end else if (NIBBLE_VALID) begin
                part_word <= merged;
                part_cnt  <= part_cnt + PCW'(1);
            end
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !accept)
                ovf <= 1'b1;
            case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (!RESET && accept)
            mem[wr_ptr] <= merged;
    end

`ifdef NIBBLE_PACKER_PARITY_EN
    logic par_mem [FIFO_DEPTH];

    always_ff @(posedge CLK) begin
        if (!RESET && accept)
            par_mem[wr_ptr] <= ^merged;
    end

    assign WORD_PAR = (level != '0) ? par_mem[rd_ptr] : 1'b0;
`endif

    assign WORD_VALID = (level != '0);
    assign WORD_OUT   = WORD_VALID ? mem[rd_ptr] : '0;
    assign FIFO_LEVEL = level;
    assign PART_COUNT = part_cnt;
    assign OVF_ERR    = ovf;

endmodule

// File: tb/tb_nibble_word_packer.sv
// Directed plus random bench for nibble_word_packer against a queue-based reference model.
module tb_nibble_word_packer;

    localparam int N = 8;
    localparam int D = 4;
    localparam int W = 4 * N;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [3:0]   NIBBLE_IN = '0;
    logic         NIBBLE_VALID = 1'b0;
    logic         FLUSH = 1'b0;
    logic [W-1:0] WORD_OUT;
    logic         WORD_VALID;
    logic         WORD_READY = 1'b0;
    logic [2:0]   FIFO_LEVEL;
    logic [2:0]   PART_COUNT;
    logic         OVF_ERR;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic         WORD_PAR;
`endif

    nibble_word_packer #(.NIBBLES_PER_WORD(N), .FIFO_DEPTH(D)) dut (
        .CLK(CLK), .RESET(RESET), .NIBBLE_IN(NIBBLE_IN), .NIBBLE_VALID(NIBBLE_VALID),
        .FLUSH(FLUSH), .WORD_OUT(WORD_OUT), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
        .FIFO_LEVEL(FIFO_LEVEL), .PART_COUNT(PART_COUNT),
`ifdef NIBBLE_PACKER_PARITY_EN
        .WORD_PAR(WORD_PAR),
`endif
        .OVF_ERR(OVF_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: nibbles held so far, queued words, sticky overflow.
    int           part_q[$];
    logic [W-1:0] fifo_q[$];
    bit           ovf_m = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] build_word();
        logic [W-1:0] w = '0;
        for (int i = 0; i < N; i++)
            w = (w << 4) | W'((i < part_q.size()) ? part_q[i] : 0);
        return w;
    endfunction

    task automatic step(input bit rst, input bit nv, input logic [3:0] nib, input bit fl, input bit rdy);
        bit           do_pop;
        bit           do_push;
        logic [W-1:0] w;
        RESET = rst; NIBBLE_VALID = nv; NIBBLE_IN = nib; FLUSH = fl; WORD_READY = rdy;
        @(posedge CLK);
        do_push = 1'b0;
        w = '0;
        if (rst) begin
            part_q.delete();
            fifo_q.delete();
            ovf_m = 1'b0;
        end else begin
            do_pop = (fifo_q.size() != 0) && rdy;
            if (nv) part_q.push_back(int'(nib));
            if (part_q.size() == N || (fl && part_q.size() > 0)) begin
                do_push = 1'b1;
                w = build_word();
                part_q.delete();
            end
            if (do_pop) void'(fifo_q.pop_front());
            if (do_push) begin
                if (fifo_q.size() < D) fifo_q.push_back(w);
                else ovf_m = 1'b1;
            end
        end
        #1;
        check("valid", 64'(WORD_VALID), 64'(fifo_q.size() != 0));
        check("word",  64'(WORD_OUT),   (fifo_q.size() != 0) ? 64'(fifo_q[0]) : 64'd0);
        check("level", 64'(FIFO_LEVEL), 64'(fifo_q.size()));
        check("part",  64'(PART_COUNT), 64'(part_q.size()));
        check("ovf",   64'(OVF_ERR),    64'(ovf_m));
`ifdef NIBBLE_PACKER_PARITY_EN
        check("par",   64'(WORD_PAR),   (fifo_q.size() != 0) ? 64'(^fifo_q[0]) : 64'd0);
`endif
    endtask

    task automatic feed(input logic [3:0] nib, input int count, input bit rdy);
        for (int i = 0; i < count; i++) step(1'b0, 1'b1, nib, 1'b0, rdy);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'h9, 1'b1, 1'b1);
        check("rst_word", 64'(WORD_OUT), 64'd0);

        // 1..8 with ready high: word visible for exactly one cycle
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 4'(i), 1'b0, 1'b1);
        check("w12345678", 64'(WORD_OUT), 64'h12345678);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("one_cycle", 64'(WORD_VALID), 64'd0);

        // Overflow: 5 words into a 4-deep FIFO with no consumer
        feed(4'hA, 40, 1'b0);
        check("ovf_level", 64'(FIFO_LEVEL), 64'd4);
        check("ovf_set", 64'(OVF_ERR), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("drain_word", 64'(WORD_OUT), 64'hAAAAAAAA);
            step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        end
        check("drained", 64'(FIFO_LEVEL), 64'd0);
        check("ovf_sticky", 64'(OVF_ERR), 64'd1);

        // Flush of a partial word, then a flush with nothing held
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hB, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("flush_word", 64'(WORD_OUT), 64'hABC00000);
        check("flush_part", 64'(PART_COUNT), 64'd0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("empty_flush", 64'(FIFO_LEVEL), 64'd1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Nibble and flush on the same edge
        step(1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hB, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hC, 1'b1, 1'b0);
        check("nf_word", 64'(WORD_OUT), 64'hABC00000);
        check("nf_level", 64'(FIFO_LEVEL), 64'd1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Full FIFO with a pop on the completing edge: no drop
        feed(4'h3, 32, 1'b0);
        feed(4'h4, 7, 1'b0);
        step(1'b0, 1'b1, 4'h4, 1'b0, 1'b1);
        check("full_pp_level", 64'(FIFO_LEVEL), 64'd4);
        check("full_pp_ovf", 64'(OVF_ERR), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Mid-word reset discards partial nibbles
        feed(4'h5, 5, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        feed(4'hF, 8, 1'b0);
        check("post_rst_word", 64'(WORD_OUT), 64'hFFFFFFFF);
        check("post_rst_level", 64'(FIFO_LEVEL), 64'd1);
`ifdef NIBBLE_PACKER_PARITY_EN
        check("par_ffff", 64'(WORD_PAR), 64'd0);
`endif
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        feed(4'h0, 6, 1'b0);
        step(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        check("w00000001", 64'(WORD_OUT), 64'h00000001);
`ifdef NIBBLE_PACKER_PARITY_EN
        check("par_0001", 64'(WORD_PAR), 64'd1);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++)
            step(($urandom_range(99) < 2), ($urandom_range(99) < 75), 4'($urandom),
                 ($urandom_range(99) < 10), ($urandom_range(99) < 40));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
